subtractor_8_serial: RTL
========================

# subtractor_8_serial

Sequential 8-bit subtractor computing diff = a − b − bin, two bits per clock, through one shared 2-bit borrow-ripple slice. It is the subtraction counterpart of the team's 8-bit structural adder. It trades three extra cycles of latency for a single slice and carries a start/busy/done handshake, so it can sit behind a control FSM in the arithmetic datapath.

## Interface
- WIDTH, 8, operand width; must be an even number ≥ 2. Slice count = WIDTH/2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  minuend; sampled only on an accepted start.
- b  input  WIDTH  subtrahend; sampled only on an accepted start.
- bin  input  1  borrow in; sampled only on an accepted start.
- start  input  1  request to begin an operation.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).

## Operation
- Reset (async, immediate): state IDLE. Clears busy, done, diff, bout, operand registers, slice counter and internal borrow to 0.
- FSM states:
  - IDLE: busy=0, done=0.
    - start=1 → latch a, b and bin into the operand and borrow registers, clear the counter, go to RUN.
  - RUN: busy=1.
    - Each cycle, the slice computes {borrow, d[1:0]} = a_reg[1:0] − b_reg[1:0] − borrow.
    - d is shifted into diff_reg from the MSB end. a_reg and b_reg shift right by 2. The borrow register takes the new borrow. The counter increments.
    - After the slice with counter = WIDTH/2−1 → go to DONE. Load diff with the assembled word and bout with the final borrow.
  - DONE: done=1 and busy=0 for exactly this one cycle.
    - start=1 → latch new operands, go to RUN (back-to-back).
    - Otherwise → IDLE.
- diff and bout hold their values from the DONE cycle until the next DONE or reset. They do not change during a subsequent RUN.
- start while in RUN is ignored: no relatch, no restart, no error.
- a, b and bin are don't-care except on the accepting edge.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and outputs return to 0.

## Timing
- Accepting edge is E0 (start=1 in IDLE or DONE).
- busy is high in the cycles after edges E0 … E0+WIDTH/2−1. For WIDTH=8 that is 4 cycles.
- done is high in the cycle after edge E0+WIDTH/2. diff and bout are valid in that same cycle.
- Latency from start to done is WIDTH/2+1 cycles (5 for WIDTH=8).
- Maximum throughput is one result per WIDTH/2+1 cycles, reached when start is held high.
- busy and done are never high together. busy and done are never high during reset.
- Width rules:
  - The slice arithmetic is 3 bits wide: bit 2 is the borrow.
  - The counter is $clog2(WIDTH/2) bits wide, with a minimum of 1 bit.
  - Wrap-around is modular: no saturation and no overflow flag. Signed interpretation is left to the consumer.

## Structure
- Shared package sub_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoded.
  - SLICE_W = 2.
- One sub-module, sub_2_slice: combinational 2-bit borrow-ripple subtractor.
  - Ports: a[1:0], b[1:0], bin, diff[1:0], bout.
  - Instantiated once.
- Top level holds the FSM, the shift registers, the counter and the output registers.

## Test plan
- Reset, then a=0x50, b=0x20, bin=0, start one cycle → busy for 4 cycles. done pulses in cycle 5 with diff=0x30, bout=0. diff holds at 0x30 afterwards.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 → diff=0x00, bout=0.
- start held high continuously with operands changing every cycle → results appear every 5 cycles. Each result matches the operands present on its accepting edge, and the other operand values are ignored.
- Assert start again in the 2nd RUN cycle with different operands → the first result is unchanged and no extra done pulse appears.
- Assert rst in the 3rd RUN cycle → busy, done, diff and bout go to 0 immediately with no done pulse. A later operation produces a correct result.
- Random regression of 10k operands against the reference model (a − b − bin) mod 256 and its borrow. Check that busy and done are never both high.

Source files
------------

// File: rtl/sub_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sub_pkg : shared types for the serial subtractor datapath
// Rev 1.0
// ----------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

endpackage
`default_nettype wire

// File: rtl/sub_2_slice.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sub_2_slice : combinational 2-bit borrow-ripple subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
module sub_2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bin,
  output logic [1:0] diff,
  output logic       bout
);

  logic w_b0;

  assign diff[0] = a[0] ^ b[0] ^ bin;
  assign w_b0    = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin);
  assign diff[1] = a[1] ^ b[1] ^ w_b0;
  assign bout    = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & w_b0);

endmodule
`default_nettype wire

// File: rtl/subtractor_8_serial.sv
`default_nettype none
// ----------------------------------------------------------------------------
// subtractor_8_serial : diff = a - b - bin, two bits per clock through one slice
// Rev 1.0
// ----------------------------------------------------------------------------
module subtractor_8_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int AW     = (WIDTH > SLICE_W) ? WIDTH - SLICE_W : SLICE_W;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_acc;

  logic [SLICE_W-1:0] w_d;
  logic               w_bo;
  logic [AW-1:0]      w_acc_next;
  logic [WIDTH-1:0]   w_word;

  sub_2_slice u_slice (
    .a    (r_a[SLICE_W-1:0]),
    .b    (r_b[SLICE_W-1:0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bo)
  );

  // Partial result fills from the MSB end, so after the last slice the
  // accumulator already sits in the low bits of the final word.
  generate
    if (WIDTH == SLICE_W) begin : g_one_slice
      assign w_word     = w_d;
      assign w_acc_next = '0;
    end else if (AW == SLICE_W) begin : g_two_slices
      assign w_word     = {w_d, r_acc};
      assign w_acc_next = w_d;
    end else begin : g_many_slices
      assign w_word     = {w_d, r_acc};
      assign w_acc_next = {w_d, r_acc[AW-1:SLICE_W]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_acc    <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a      <= r_a >> SLICE_W;
          r_b      <= r_b >> SLICE_W;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CW'(1);
          r_acc    <= w_acc_next;
          if (r_cnt == LAST) begin
            diff    <= w_word;
            bout    <= w_bo;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
